// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, imem request issue,
// in-order prefetch queue to ID. Optional same-cycle bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pcnext,
  output logic [$clog2(DEPTH):0] fq_count,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] rpc_q, rpc_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] last_inst_q, last_inst_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;

  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic credit, req_fire, rsp_live, rsp_keep;
  logic q_empty, byp, pop, pop_q, byp_take, push;

  assign credit = ({1'b0, cnt_q} + {1'b0, out_q}) < (CW+1)'(DEPTH);
  assign imem_req_valid = rst_n && !redirect_valid && credit;
  assign imem_addr = fpc_q;
  assign req_fire = imem_req_valid && imem_req_ready;

  // A response with nothing in flight is spurious and only flags rsp_err.
  assign rsp_live = imem_rsp_valid && (out_q != '0);
  assign rsp_keep = rsp_live && (drop_q == '0) && !redirect_valid;
  assign q_empty = (cnt_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = q_empty && rsp_keep;
`else
  assign byp = 1'b0;
`endif

  assign id_valid = !q_empty || byp;

  always_comb begin
    id_inst = last_inst_q;
    id_pc = last_pc_q;
    if (!q_empty) begin
      id_inst = inst_mem[head_q];
      id_pc = pc_mem[head_q];
    end else if (byp) begin
      id_inst = imem_rsp_data;
      id_pc = rpc_q;
    end
  end

  assign id_pcnext = id_pc + STEP;
  assign fq_count = cnt_q;
  assign rsp_err = err_q;

  assign pop = id_valid && id_ready && !redirect_valid;
  assign pop_q = pop && !q_empty;
  assign byp_take = pop && q_empty;
  assign push = rsp_keep && !byp_take;

  always_comb begin
    fpc_d = fpc_q;
    rpc_d = rpc_q;
    drop_d = drop_q;
    cnt_d = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    last_inst_d = last_inst_q;
    last_pc_d = last_pc_q;
    out_d = out_q + CW'(req_fire) - CW'(rsp_live);
    err_d = err_q || (imem_rsp_valid && out_q == '0);
    if (redirect_valid) begin
      fpc_d = redirect_pc;
      rpc_d = redirect_pc;
      head_d = '0;
      tail_d = '0;
      cnt_d = '0;
      // drop_q is a subset of out_q, so every response still in flight
      // after this edge belongs to a squashed path.
      drop_d = out_q - CW'(rsp_live);
    end else begin
      if (req_fire) fpc_d = fpc_q + STEP;
      if (rsp_live && drop_q != '0) drop_d = drop_q - CW'(1);
      if (push || byp_take) rpc_d = rpc_q + STEP;
      if (push) tail_d = tail_q + AW'(1);
      if (pop_q) head_d = head_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop_q);
      if (pop) begin
        last_inst_d = id_inst;
        last_pc_d = id_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q <= RESET_PC;
      rpc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
      cnt_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      err_q <= 1'b0;
      last_inst_q <= '0;
      last_pc_q <= '0;
    end else begin
      fpc_q <= fpc_d;
      rpc_q <= rpc_d;
      out_q <= out_d;
      drop_q <= drop_d;
      cnt_q <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      err_q <= err_d;
      last_inst_q <= last_inst_d;
      last_pc_q <= last_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail_q] <= imem_rsp_data;
      pc_mem[tail_q] <= rpc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build, DEPTH=4):
// per-cycle vector table plus reset and spurious-response sequences.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pcnext;
  logic [2:0]  fq_count;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .id_pcnext(id_pcnext),
    .fq_count(fq_count), .rsp_err(rsp_err)
  );

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        idr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_idv;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] I(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  function automatic vec_t mk(
    input logic rd, input logic [31:0] rpc, input logic rdy,
    input logic rv, input logic [31:0] rdata, input logic idr,
    input logic e_req, input logic [31:0] e_addr, input logic e_idv,
    input logic [31:0] e_pc, input logic [31:0] e_inst, input int e_cnt);
    vec_t v;
    v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.rv = rv;
    v.rdata = rdata; v.idr = idr; v.e_req = e_req;
    v.e_addr = e_addr; v.e_idv = e_idv; v.e_pc = e_pc;
    v.e_inst = e_inst; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic e_err);
    chk({tag, "_req_valid"}, 0, 32'(imem_req_valid), 32'(rst_n));
    chk({tag, "_fq_count"}, 0, 32'(fq_count), 0);
    chk({tag, "_id_valid"}, 0, 32'(id_valid), 0);
    chk({tag, "_rsp_err"}, 0, 32'(rsp_err), 32'(e_err));
  endtask

  initial begin
    // rd rpc rdy rv rdata idr | req addr idv pc inst cnt
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 32'h0, 0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 1, 1, I(32'h0), 1, 1, 32'h4, 0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 1, 1, I(32'h4), 1, 1, 32'h8, 1, 32'h0, I(32'h0), 1));
    vecs.push_back(mk(0, 0, 0, 1, I(32'h8), 1, 1, 32'hC, 1, 32'h4, I(32'h4), 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'hC, 1, 32'h8, I(32'h8), 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'hC, 0, 32'h8, I(32'h8), 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 32'hC, 0, 32'h8, I(32'h8), 0));
    vecs.push_back(mk(0, 0, 1, 1, I(32'hC), 0, 1, 32'h10, 0, 32'h8, I(32'h8), 0));
    vecs.push_back(mk(0, 0, 1, 1, I(32'h10), 0, 1, 32'h14, 1, 32'hC, I(32'hC), 1));
    vecs.push_back(mk(0, 0, 1, 1, I(32'h14), 0, 1, 32'h18, 1, 32'hC, I(32'hC), 2));
    vecs.push_back(mk(0, 0, 1, 1, I(32'h18), 0, 0, 32'h1C, 1, 32'hC, I(32'hC), 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h1C, 1, 32'hC, I(32'hC), 4));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 32'h1C, 1, 32'hC, I(32'hC), 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1C, 1, 32'h10, I(32'h10), 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 32'h1C, 1, 32'h10, I(32'h10), 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 32'h20, 1, 32'h14, I(32'h14), 2));
    // redirect with 2 outstanding, 2 queued
    vecs.push_back(mk(1, 32'h100, 1, 0, 0, 1, 0, 32'h24, 1, 32'h14, I(32'h14), 2));
    vecs.push_back(mk(0, 0, 1, 1, 32'hDEAD0001, 1, 1, 32'h100, 0, 32'h10, I(32'h10), 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hDEAD0002, 1, 1, 32'h104, 0, 32'h10, I(32'h10), 0));
    vecs.push_back(mk(0, 0, 0, 1, I(32'h100), 1, 1, 32'h104, 0, 32'h10, I(32'h10), 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h104, 1, 32'h100, I(32'h100), 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 32'h104, 0, 32'h100, I(32'h100), 0));
    vecs.push_back(mk(0, 0, 0, 1, I(32'h104), 0, 1, 32'h108, 0, 32'h100, I(32'h100), 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 32'h108, 1, 32'h104, I(32'h104), 1));
    // redirect + response + pop in one cycle, target near the top of memory
    vecs.push_back(mk(1, 32'hFFFF_FFF8, 1, 1, I(32'h108), 1, 0, 32'h10C, 1, 32'h104, I(32'h104), 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 32'h100, I(32'h100), 0));
    vecs.push_back(mk(0, 0, 1, 1, I(32'hFFFF_FFF8), 0, 1, 32'hFFFF_FFFC, 0, 32'h100, I(32'h100), 0));
    vecs.push_back(mk(0, 0, 1, 1, I(32'hFFFF_FFFC), 0, 1, 32'h0, 1, 32'hFFFF_FFF8, I(32'hFFFF_FFF8), 1));
    vecs.push_back(mk(0, 0, 0, 1, I(32'h0), 1, 1, 32'h4, 1, 32'hFFFF_FFF8, I(32'hFFFF_FFF8), 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h4, 1, 32'hFFFF_FFFC, I(32'hFFFF_FFFC), 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h4, 1, 32'h0, I(32'h0), 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h4, 0, 32'h0, I(32'h0), 0));

    // reset values
    @(negedge clk);
    #1;
    chk("rst_req_valid", 0, 32'(imem_req_valid), 0);
    chk("rst_addr", 0, imem_addr, 32'h0);
    chk("rst_id_valid", 0, 32'(id_valid), 0);
    chk("rst_id_inst", 0, id_inst, 32'h0);
    chk("rst_id_pc", 0, id_pc, 32'h0);
    chk("rst_id_pcnext", 0, id_pcnext, 32'h4);
    chk("rst_fq_count", 0, 32'(fq_count), 0);
    chk("rst_rsp_err", 0, 32'(rsp_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      redirect_valid = vecs[i].rd;
      redirect_pc = vecs[i].rpc;
      imem_req_ready = vecs[i].rdy;
      imem_rsp_valid = vecs[i].rv;
      imem_rsp_data = vecs[i].rdata;
      id_ready = vecs[i].idr;
      #1;
      chk("req_valid", i, 32'(imem_req_valid), 32'(vecs[i].e_req));
      chk("imem_addr", i, imem_addr, vecs[i].e_addr);
      chk("id_valid", i, 32'(id_valid), 32'(vecs[i].e_idv));
      chk("id_pc", i, id_pc, vecs[i].e_pc);
      chk("id_pcnext", i, id_pcnext, vecs[i].e_pc + 32'h4);
      chk("id_inst", i, id_inst, vecs[i].e_inst);
      chk("fq_count", i, 32'(fq_count), 32'(vecs[i].e_cnt));
      chk("rsp_err", i, 32'(rsp_err), 0);
    end

    // asynchronous reset with a request in flight
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    id_ready = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", 0, imem_addr, 32'h0);
    chk("mid_rst_id_pc", 0, id_pc, 32'h0);
    chk("mid_rst_id_inst", 0, id_inst, 32'h0);
    chk_idle("mid_rst", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // spurious response with nothing outstanding
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hBAD0_BAD0;
    #1;
    chk_idle("spur_pre", 1'b0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    #1;
    chk_idle("spur_post", 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk_idle("spur_sticky", 1'b1);
    chk("spur_addr", 0, imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
